// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier.
// One multiplier bit is consumed per clock, LSB first. Signed operands are
// reduced to magnitudes at acceptance and the sign is applied once, when the
// final sum is written to the product register.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   sum;
    logic [WIDTH-1:0]     mplier;
    logic [CNT_W-1:0]     cnt;
    logic                 negate;
    logic                 last;

    // Magnitude of an operand. The most-negative value maps onto its own bit
    // pattern, which read as unsigned is exactly 2**(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic use_sign);
        if (use_sign && (v < 0))
            return -v;
        return v;
    endfunction

    // Apply the result sign; a zero magnitude is never negated.
    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] mag,
                                                      input logic neg);
        if (neg && (mag != '0))
            return -mag;
        return mag;
    endfunction

    assign sum  = acc + (mplier[0] ? mcand : '0);
    assign last = (cnt == CNT_W'(WIDTH - 1));
    assign busy = (state == CALC);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic: IDLE -> CALC on start, WIDTH CALC edges, one DONE cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on acceptance, accumulate one bit per CALC edge,
    // and write the signed-corrected product on the final CALC edge only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            negate  <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, magnitude($signed(a), signed_mode)};
                        mplier <= magnitude($signed(b), signed_mode);
                        acc    <= '0;
                        cnt    <= '0;
                        negate <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    end
                end
                CALC: begin
                    acc    <= sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last)
                        product <= apply_sign(sum, negate);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: one 4-bit and one 8-bit instance on a shared
// clock and reset, exercised with directed vectors and a reference-model soak.
module tb_seq_multiplier;

    logic        clk;
    logic        rst_n;

    logic        start4, sm4, busy4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  product4;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    int errors = 0;
    int checks = 0;
    int acc4 = 0, acc8 = 0;
    int dcount4 = 0, dcount8 = 0;
    logic [7:0]  last4 = '0;
    logic [15:0] last8 = '0;

    seq_multiplier #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .product(product4)
    );

    seq_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(product8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done4 === 1'b1) dcount4 <= dcount4 + 1;
        if (done8 === 1'b1) dcount8 <= dcount8 + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref4(input logic sm, input logic [3:0] x, input logic [3:0] y);
        int sx, sy;
        sx = sm ? int'($signed(x)) : int'(x);
        sy = sm ? int'($signed(y)) : int'(y);
        return 8'(sx * sy);
    endfunction

    function automatic logic [15:0] ref8(input logic sm, input logic [7:0] x, input logic [7:0] y);
        int sx, sy;
        sx = sm ? int'($signed(x)) : int'(x);
        sy = sm ? int'($signed(y)) : int'(y);
        return 16'(sx * sy);
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic mul4(input logic sm, input logic [3:0] x, input logic [3:0] y,
                        input logic [7:0] exp, input string tag);
        start4 = 1'b1; sm4 = sm; a4 = x; b4 = y;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check({tag, ".busy"}, busy4, 1'b1);
            check({tag, ".done_early"}, done4, 1'b0);
            if (i == 0) check({tag, ".hold"}, product4, last4);
            start4 = 1'($urandom_range(0, 1));
            a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        start4 = 1'b0;
        check({tag, ".done"}, done4, 1'b1);
        check({tag, ".busy_off"}, busy4, 1'b0);
        check({tag, ".product"}, product4, exp);
        last4 = exp;
        acc4++;
        @(negedge clk);
        check({tag, ".done_pulse"}, done4, 1'b0);
        check({tag, ".idle"}, busy4, 1'b0);
    endtask

    task automatic mul8(input logic sm, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] exp, input string tag);
        start8 = 1'b1; sm8 = sm; a8 = x; b8 = y;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check({tag, ".busy"}, busy8, 1'b1);
            check({tag, ".done_early"}, done8, 1'b0);
            if (i == 0) check({tag, ".hold"}, product8, last8);
            start8 = 1'($urandom_range(0, 1));
            a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        start8 = 1'b0;
        check({tag, ".done"}, done8, 1'b1);
        check({tag, ".busy_off"}, busy8, 1'b0);
        check({tag, ".product"}, product8, exp);
        last8 = exp;
        acc8++;
        @(negedge clk);
        check({tag, ".done_pulse"}, done8, 1'b0);
        check({tag, ".idle"}, busy8, 1'b0);
    endtask

    initial begin
        logic sm;
        logic [3:0] x4, y4;
        logic [7:0] x8, y8;
        int saw_done;

        rst_n = 1'b0;
        start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst.busy4", busy4, 1'b0);
        check("rst.done4", done4, 1'b0);
        check("rst.product4", product4, 8'h00);
        check("rst.busy8", busy8, 1'b0);
        check("rst.done8", done8, 1'b0);
        check("rst.product8", product8, 16'h0000);

        // WIDTH=4 directed vectors
        mul4(1'b0, 4'h5, 4'h5, 8'h19, "u4_5x5");
        mul4(1'b0, 4'hF, 4'hF, 8'hE1, "u4_FxF");
        mul4(1'b0, 4'h0, 4'hF, 8'h00, "u4_0xF");
        mul4(1'b1, 4'h8, 4'h8, 8'h40, "s4_m8xm8");
        mul4(1'b1, 4'hF, 4'h1, 8'hFF, "s4_m1x1");
        mul4(1'b1, 4'h0, 4'hF, 8'h00, "s4_0xm1");
        mul4(1'b1, 4'h3, 4'hA, 8'hEE, "s4_3xm6");

        // WIDTH=8 directed vectors
        mul8(1'b1, 8'h80, 8'h80, 16'h4000, "s8_m128xm128");
        mul8(1'b1, 8'hFD, 8'h05, 16'hFFF1, "s8_m3x5");
        mul8(1'b1, 8'h80, 8'h7F, 16'hC080, "s8_m128x127");
        mul8(1'b1, 8'h00, 8'hFF, 16'h0000, "s8_0xm1");
        mul8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "u8_FFxFF");
        mul8(1'b0, 8'h80, 8'h80, 16'h4000, "u8_80x80");

        // Product holds through idle cycles
        repeat (5) @(negedge clk);
        check("hold_idle8", product8, 16'h4000);
        check("hold_idle4", product4, 8'hEE);

        // Start held high, operands scrambled during CALC
        start8 = 1'b1; sm8 = 1'b1; a8 = 8'hFD; b8 = 8'h05;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("held.busy", busy8, 1'b1);
            a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("held.done", done8, 1'b1);
        check("held.product", product8, 16'hFFF1);
        acc8++;
        sm8 = 1'b0; a8 = 8'd7; b8 = 8'd9;
        @(negedge clk);
        check("held.no_restart_busy", busy8, 1'b0);
        check("held.no_restart_done", done8, 1'b0);
        @(negedge clk);
        check("held.reaccept", busy8, 1'b1);
        start8 = 1'b0;
        for (int i = 1; i < 8; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom);
            @(negedge clk);
            check("held2.busy", busy8, 1'b1);
        end
        @(negedge clk);
        check("held2.done", done8, 1'b1);
        check("held2.product", product8, 16'h003F);
        acc8++;
        @(negedge clk);
        check("held2.idle", done8, 1'b0);

        // Reset mid-CALC
        start8 = 1'b1; sm8 = 1'b0; a8 = 8'h55; b8 = 8'h33;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        check("abort.busy_before", busy8, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort.busy", busy8, 1'b0);
        check("abort.done", done8, 1'b0);
        check("abort.product8", product8, 16'h0000);
        check("abort.product4", product4, 8'h00);
        saw_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 !== 1'b0 || busy8 !== 1'b0) saw_done = 1;
        end
        check("abort.no_done", 1'(saw_done), 1'b0);
        last8 = '0;
        last4 = '0;
        mul8(1'b0, 8'd7, 8'd9, 16'h003F, "after_rst_7x9");

        // Random soak against the reference model
        for (int n = 0; n < 1000; n++) begin
            sm = 1'($urandom_range(0, 1));
            x4 = 4'($urandom); y4 = 4'($urandom);
            mul4(sm, x4, y4, ref4(sm, x4, y4), "soak4");
        end
        for (int n = 0; n < 1000; n++) begin
            sm = 1'($urandom_range(0, 1));
            x8 = 8'($urandom); y8 = 8'($urandom);
            mul8(sm, x8, y8, ref8(sm, x8, y8), "soak8");
        end

        @(negedge clk);
        check("done_count4", 32'(dcount4), 32'(acc4));
        check("done_count8", 32'(dcount8), 32'(acc8));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
